// File: rtl/intersection_scheduler_pkg.sv
// Shared types for the intersection scheduler: light encodings, phase and
// direction enums, and light decode helpers for each phase.
package intersection_scheduler_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_EW_GREEN  = 3'd2,
    S_EW_YELLOW = 3'd3,
    S_CLEAR     = 3'd4,
    S_WALK      = 3'd5
  } phase_t;

  typedef enum logic {DIR_NS = 1'b0, DIR_EW = 1'b1} dir_t;

  function automatic logic [1:0] ns_light_of(input phase_t p);
    case (p)
      S_NS_GREEN:  return GREEN;
      S_NS_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_light_of(input phase_t p);
    case (p)
      S_EW_GREEN:  return GREEN;
      S_EW_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

  function automatic logic ped_light_of(input phase_t p);
    case (p)
      S_WALK:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request/light bundle between the requesters (master) and the scheduler
// (slave). Optional WALK_COUNT_EN adds the pedestrian countdown signal.
interface intersection_scheduler_if
`ifdef WALK_COUNT_EN
  #(parameter int TW = 5)
`endif
  ;
  logic       ns_car_req;
  logic       ew_car_req;
  logic       pedestrian_btn;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       pedestrian_light;
`ifdef WALK_COUNT_EN
  logic [TW-1:0] walk_remaining;
`endif

  modport master (
`ifdef WALK_COUNT_EN
    input  walk_remaining,
`endif
    output ns_car_req, ew_car_req, pedestrian_btn,
    input  ns_light, ew_light, pedestrian_light
  );

  modport slave (
`ifdef WALK_COUNT_EN
    output walk_remaining,
`endif
    input  ns_car_req, ew_car_req, pedestrian_btn,
    output ns_light, ew_light, pedestrian_light
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Cycles-in-phase counter: zero on the first cycle of each phase, saturating
// so it can never wrap back into a terminal-count match.
module intersection_scheduler_phase_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] count
);

  logic [TW-1:0] count_r;

  // Count up while the phase holds; restart whenever the phase changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {TW{1'b0}};
    end else if (clr) begin
      count_r <= {TW{1'b0}};
    end else if (count_r != {TW{1'b1}}) begin
      count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/intersection_scheduler.sv
// Phase scheduler for a two-way intersection with a pedestrian phase.
// Moore FSM; lights are registered decodes of the phase register.
// Optional macro WALK_COUNT_EN adds the walk_remaining countdown output.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input logic                     clk,
  input logic                     rst,
  intersection_scheduler_if.slave bus
);

  localparam int TW = $clog2(GREEN_MAX + 1);

  phase_t        state_r;
  phase_t        next_state_s;
  dir_t          next_dir_r;
  logic          ped_pending_r;
  logic          from_walk_r;
  logic          state_chg_s;
  logic [TW-1:0] tmr_s;
  logic [1:0]    ns_light_r;
  logic [1:0]    ew_light_r;
  logic          ped_light_r;

  intersection_scheduler_phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_chg_s),
    .count (tmr_s)
  );

  // Next-phase selection from the timer, the opposing demand and ped_pending.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_NS_GREEN: begin
        if ((tmr_s == TW'(GREEN_MAX - 1)) ||
            ((tmr_s >= TW'(GREEN_MIN - 1)) && (bus.ew_car_req || ped_pending_r)))
          next_state_s = S_NS_YELLOW;
        else
          next_state_s = S_NS_GREEN;
      end
      S_EW_GREEN: begin
        if ((tmr_s == TW'(GREEN_MAX - 1)) ||
            ((tmr_s >= TW'(GREEN_MIN - 1)) && (bus.ns_car_req || ped_pending_r)))
          next_state_s = S_EW_YELLOW;
        else
          next_state_s = S_EW_GREEN;
      end
      S_NS_YELLOW, S_EW_YELLOW: begin
        if (tmr_s == TW'(YELLOW_T - 1))
          next_state_s = S_CLEAR;
        else
          next_state_s = state_r;
      end
      S_WALK: begin
        if (tmr_s == TW'(WALK_T - 1))
          next_state_s = S_CLEAR;
        else
          next_state_s = S_WALK;
      end
      S_CLEAR: begin
        if (tmr_s != TW'(ALLRED_T - 1))
          next_state_s = S_CLEAR;
        else if (ped_pending_r && !from_walk_r)
          next_state_s = S_WALK;
        else if (next_dir_r == DIR_NS)
          next_state_s = S_NS_GREEN;
        else
          next_state_s = S_EW_GREEN;
      end
      default: next_state_s = S_CLEAR;
    endcase
    state_chg_s = (next_state_s != state_r);
  end

  // Phase register, registered lights, and the direction/pedestrian bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_CLEAR;
      next_dir_r    <= DIR_NS;
      ped_pending_r <= 1'b0;
      from_walk_r   <= 1'b0;
      ns_light_r    <= RED;
      ew_light_r    <= RED;
      ped_light_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      ns_light_r  <= ns_light_of(next_state_s);
      ew_light_r  <= ew_light_of(next_state_s);
      ped_light_r <= ped_light_of(next_state_s);

      // Directions alternate strictly: each green entry hands over to the other.
      if (state_chg_s && (next_state_s == S_NS_GREEN))
        next_dir_r <= DIR_EW;
      else if (state_chg_s && (next_state_s == S_EW_GREEN))
        next_dir_r <= DIR_NS;
      else
        next_dir_r <= next_dir_r;

      // Entering WALK serves the request; presses during WALK are ignored.
      if (state_chg_s && (next_state_s == S_WALK))
        ped_pending_r <= 1'b0;
      else if (bus.pedestrian_btn && (state_r != S_WALK))
        ped_pending_r <= 1'b1;
      else
        ped_pending_r <= ped_pending_r;

      // Remember that this clearance follows a WALK so a car phase comes next.
      if (state_chg_s && (state_r == S_WALK))
        from_walk_r <= 1'b1;
      else if (state_chg_s && (state_r == S_CLEAR))
        from_walk_r <= 1'b0;
      else
        from_walk_r <= from_walk_r;
    end
  end

  assign bus.ns_light         = ns_light_r;
  assign bus.ew_light         = ew_light_r;
  assign bus.pedestrian_light = ped_light_r;

`ifdef WALK_COUNT_EN
  logic [TW-1:0] walk_rem_r;

  // Countdown equal to WALK_T - tmr while walking, zero in every other phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      walk_rem_r <= {TW{1'b0}};
    end else if (next_state_s == S_WALK) begin
      if (state_r != S_WALK)
        walk_rem_r <= TW'(WALK_T);
      else
        walk_rem_r <= walk_rem_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      walk_rem_r <= {TW{1'b0}};
    end
  end

  assign bus.walk_remaining = walk_rem_r;
`endif

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: a vector table, hand-written
// multi-cycle sequences, and randomized traffic against a phase-script model.
module tb_intersection_scheduler;
  import intersection_scheduler_pkg::*;

  localparam int GMIN = 4;
  localparam int GMAX = 16;
  localparam int YT   = 2;
  localparam int AT   = 1;
  localparam int WT   = 6;

  localparam int TK_Y    = 0;
  localparam int TK_CLR  = 1;
  localparam int TK_WALK = 2;
  localparam int TK_DEC  = 3;
  localparam int TK_GRN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef WALK_COUNT_EN
  intersection_scheduler_if #(.TW(5)) bus ();
`else
  intersection_scheduler_if bus ();
`endif

  intersection_scheduler #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .WALK_T    (WT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a green phase is open-ended; everything else is a
  // script of one token per cycle, with a decision point at clearance end.
  int   q[$];
  bit   m_green = 1'b0;
  bit   m_dir   = 1'b0;
  bit   m_nd    = 1'b0;
  bit   m_pend  = 1'b0;
  int   m_gcnt  = 0;

  function automatic void push_n(input int tk, input int n);
    for (int i = 0; i < n; i++) q.push_back(tk);
  endfunction

  function automatic void model_step(input logic r, input logic n, input logic e, input logic b);
    bit old_walk, new_walk, pend_old, other;
    if (!r) begin
      q.delete();
      push_n(TK_CLR, AT);
      q.push_back(TK_DEC);
      m_green = 1'b0; m_nd = 1'b0; m_dir = 1'b0; m_pend = 1'b0;
      return;
    end
    old_walk = !m_green && q.size() > 0 && q[0] == TK_WALK;
    pend_old = m_pend;
    if (m_green) begin
      other = m_dir ? n : e;
      if (m_gcnt >= GMAX || (m_gcnt >= GMIN && (other || pend_old))) begin
        m_green = 1'b0;
        q.delete();
        push_n(TK_Y, YT);
        push_n(TK_CLR, AT);
        q.push_back(TK_DEC);
      end else begin
        m_gcnt++;
      end
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() > 0 && q[0] == TK_DEC) begin
        void'(q.pop_front());
        if (pend_old) begin
          push_n(TK_WALK, WT);
          push_n(TK_CLR, AT);
        end
        q.push_back(TK_GRN);
      end
      if (q.size() > 0 && q[0] == TK_GRN) begin
        q.delete();
        m_green = 1'b1; m_dir = m_nd; m_nd = !m_nd; m_gcnt = 1;
      end
    end
    new_walk = !m_green && q.size() > 0 && q[0] == TK_WALK;
    if (new_walk && !old_walk) m_pend = 1'b0;
    else if (b && !old_walk)   m_pend = 1'b1;
  endfunction

  function automatic void model_lights(output logic [1:0] ens, output logic [1:0] eew, output logic eped);
    ens = RED; eew = RED; eped = 1'b0;
    if (m_green) begin
      if (m_dir) eew = GREEN; else ens = GREEN;
    end else if (q.size() > 0) begin
      if (q[0] == TK_Y) begin
        if (m_dir) eew = YELLOW; else ens = YELLOW;
      end else if (q[0] == TK_WALK) begin
        eped = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic r, input logic n, input logic e, input logic b);
    @(negedge clk);
    rst = r; bus.ns_car_req = n; bus.ew_car_req = e; bus.pedestrian_btn = b;
    @(posedge clk);
    model_step(r, n, e, b);
    #1;
  endtask

  task automatic check_lights(input string name, input logic [1:0] ens, input logic [1:0] eew, input logic eped);
    vectors++;
    if (bus.ns_light !== ens || bus.ew_light !== eew || bus.pedestrian_light !== eped) begin
      miscompares++;
      $display("FAIL %s @%0t: got ns=%b ew=%b ped=%b, expected ns=%b ew=%b ped=%b",
               name, $time, bus.ns_light, bus.ew_light, bus.pedestrian_light, ens, eew, eped);
    end
  endtask

  task automatic expect_run(input int cnt, input logic n, input logic e, input logic b,
                            input logic [1:0] ens, input logic [1:0] eew, input logic eped,
                            input string name);
    for (int i = 0; i < cnt; i++) begin
      step(1'b1, n, e, b);
      check_lights(name, ens, eew, eped);
    end
  endtask

  task automatic do_reset(input logic b);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, b);
      check_lights("reset_red", RED, RED, 1'b0);
    end
  endtask

  typedef struct {
    logic       r, n, e, b;
    logic [1:0] ens, eew;
    logic       eped;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [1:0] ens, eew;
    logic       eped, r, n, e, b;
    logic       prev_both_red;
    int         ns_run, ew_run;

    bus.ns_car_req = 1'b0; bus.ew_car_req = 1'b0; bus.pedestrian_btn = 1'b0;

    // Table: reset, then EW demand cuts NS green to the minimum, then NS demand.
    for (int i = 0; i < 3; i++)   tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0};
    for (int i = 3; i < 7; i++)   tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, GREEN, RED, 1'b0};
    for (int i = 7; i < 9; i++)   tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, YELLOW, RED, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, RED, RED, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, RED, GREEN, 1'b0};
    for (int i = 11; i < 14; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, RED, GREEN, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, RED, YELLOW, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, RED, YELLOW, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].n, tbl[i].e, tbl[i].b);
      check_lights($sformatf("tbl[%0d]", i), tbl[i].ens, tbl[i].eew, tbl[i].eped);
    end

    // No requests: NS green runs to the maximum, then hands over to EW.
    do_reset(1'b0);
    expect_run(GMAX, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0, "idle_ns_green");
    expect_run(YT,   1'b0, 1'b0, 1'b0, YELLOW, RED, 1'b0, "idle_ns_yellow");
    expect_run(AT,   1'b0, 1'b0, 1'b0, RED, RED, 1'b0, "idle_clear");
    expect_run(1,    1'b0, 1'b0, 1'b0, RED, GREEN, 1'b0, "idle_ew_green");

    // One-cycle pedestrian pulse at NS tmr=1.
    do_reset(1'b0);
    expect_run(2,  1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0, "ped_ns_green");
    expect_run(1,  1'b0, 1'b0, 1'b1, GREEN, RED, 1'b0, "ped_ns_green");
    expect_run(1,  1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0, "ped_ns_green");
    expect_run(YT, 1'b0, 1'b0, 1'b0, YELLOW, RED, 1'b0, "ped_ns_yellow");
    expect_run(AT, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, "ped_clear1");
    expect_run(WT, 1'b0, 1'b0, 1'b0, RED, RED, 1'b1, "ped_walk");
    expect_run(AT, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, "ped_clear2");
    expect_run(GMAX, 1'b0, 1'b0, 1'b0, RED, GREEN, 1'b0, "ped_ew_full_green");
    expect_run(1,  1'b0, 1'b0, 1'b0, RED, YELLOW, 1'b0, "ped_ew_yellow");

    // Button held: WALKs alternate with minimum-length car greens.
    do_reset(1'b1);
    expect_run(GMIN, 1'b0, 1'b0, 1'b1, GREEN, RED, 1'b0, "held_ns_green");
    expect_run(YT,   1'b0, 1'b0, 1'b1, YELLOW, RED, 1'b0, "held_ns_yellow");
    expect_run(AT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b0, "held_clear");
    expect_run(WT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b1, "held_walk1");
    expect_run(AT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b0, "held_clear");
    expect_run(GMIN, 1'b0, 1'b0, 1'b1, RED, GREEN, 1'b0, "held_ew_green");
    expect_run(YT,   1'b0, 1'b0, 1'b1, RED, YELLOW, 1'b0, "held_ew_yellow");
    expect_run(AT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b0, "held_clear");
    expect_run(WT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b1, "held_walk2");
    expect_run(AT,   1'b0, 1'b0, 1'b1, RED, RED, 1'b0, "held_clear");
    expect_run(1,    1'b0, 1'b0, 1'b1, GREEN, RED, 1'b0, "held_ns_again");

    // Reset in the middle of NS green.
    do_reset(1'b0);
    expect_run(3, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0, "midrst_green");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_lights("midrst_red", RED, RED, 1'b0);
    expect_run(1, 1'b0, 1'b0, 1'b0, GREEN, RED, 1'b0, "midrst_restart_ns");

    // Random traffic against the model plus the safety invariants.
    do_reset(1'b0);
    prev_both_red = 1'b1;
    ns_run = 0; ew_run = 0;
    n = 1'b0; e = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 7) == 0) n = ~n;
      if ($urandom_range(0, 7) == 0) e = ~e;
      b = ($urandom_range(0, 24) == 0);
      step(r, n, e, b);
      model_lights(ens, eew, eped);
      check_lights("rand_model", ens, eew, eped);

      vectors++;
      if (bus.ns_light != RED && bus.ew_light != RED) begin
        miscompares++;
        $display("FAIL rand_exclusive @%0t: ns=%b ew=%b, required one of them RED",
                 $time, bus.ns_light, bus.ew_light);
      end
      if (bus.pedestrian_light) begin
        vectors++;
        if (!(bus.ns_light == RED && bus.ew_light == RED && prev_both_red)) begin
          miscompares++;
          $display("FAIL rand_ped_clear @%0t: ped=1 ns=%b ew=%b prev_both_red=%b, required all RED now and before",
                   $time, bus.ns_light, bus.ew_light, prev_both_red);
        end
      end
      ns_run = (bus.ns_light == GREEN) ? ns_run + 1 : 0;
      ew_run = (bus.ew_light == GREEN) ? ew_run + 1 : 0;
      vectors++;
      if (ns_run > GMAX || ew_run > GMAX) begin
        miscompares++;
        $display("FAIL rand_green_max @%0t: green run ns=%0d ew=%0d, required <= %0d",
                 $time, ns_run, ew_run, GMAX);
      end
      prev_both_red = (bus.ns_light == RED && bus.ew_light == RED);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
